// File: rtl/byte_serializer_pkg.sv
// Shared types and constants for the byte serializer: FSM state encoding,
// bus widths and the frame start index helper.
package byte_serializer_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned LAST_BIT = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Select index of the first bit sent in a frame.
  function automatic logic [SEL_W-1:0] first_sel(input logic lsb_first);
    return lsb_first ? SEL_W'(0) : SEL_W'(LAST_BIT);
  endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Byte-in / bit-out bus of the serializer; slave is the serializer, master the
// byte source plus serial consumer.
interface byte_serializer_if;
  import byte_serializer_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [SEL_W-1:0]  sel;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_first;
  logic              ser_last;

  modport slave (
    input  in_valid, in_data,
    output in_ready, sel, ser_out, ser_valid, ser_first, ser_last
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, sel, ser_out, ser_valid, ser_first, ser_last
  );

endinterface

// File: rtl/byte_serializer_mux8to1.sv
// 8-to-1 bit multiplexer: F is d[s].
module mux8to1 (
  input  logic [2:0] s,
  input  logic [7:0] d,
  output logic       F
);

  assign F = d[s];

endmodule

// File: rtl/byte_serializer.sv
// Serializes one accepted byte into 8 bit periods of BIT_CYCLES clocks each,
// driving the mux select and framing strobes; back-to-back frames have no bubble.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int unsigned LSB_FIRST  = 1,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  byte_serializer_if.slave   bus
);

  localparam int unsigned CW = $clog2(BIT_CYCLES) + 1;

  state_e            state;
  logic [DATA_W-1:0] hold;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  bit_cnt;
  logic [CW-1:0]     cyc;
  logic              mux_bit;
  logic              cyc_last;
  logic              frame_end;
  logic              ready;
  logic              accept;

  assign cyc_last  = (cyc == CW'(BIT_CYCLES - 1));
  assign frame_end = (state == SEND) && (bit_cnt == SEL_W'(LAST_BIT)) && cyc_last;
  assign ready     = !rst && ((state == IDLE) || frame_end);
  assign accept    = bus.in_valid && ready;

  // Frame state: enter SEND on accept, leave only when the last bit ends unreloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= SEND;
        SEND:    if (frame_end && !accept) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Held byte, select, per-bit cycle counter and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= '0;
      sel_q   <= '0;
      cyc     <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      hold    <= bus.in_data;
      sel_q   <= first_sel(LSB_FIRST != 0);
      cyc     <= '0;
      bit_cnt <= '0;
    end else if (state == SEND) begin
      if (cyc_last) begin
        cyc     <= '0;
        sel_q   <= (LSB_FIRST != 0) ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
        bit_cnt <= bit_cnt + SEL_W'(1);
      end else begin
        cyc     <= cyc + CW'(1);
      end
    end
  end

  mux8to1 u_mux (
    .s (sel_q),
    .d (hold),
    .F (mux_bit)
  );

  assign bus.in_ready  = ready;
  assign bus.sel       = sel_q;
  assign bus.ser_valid = (state == SEND);
  assign bus.ser_out   = (state == SEND) && mux_bit;
  assign bus.ser_first = (state == SEND) && (bit_cnt == SEL_W'(0));
  assign bus.ser_last  = (state == SEND) && (bit_cnt == SEL_W'(LAST_BIT));

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: three instances cover LSB-first, MSB-first
// and multi-cycle bit periods; expected streams are written out by hand.
module tb_byte_serializer;

  logic clk;
  logic rst;
  int   checks;
  int   errs;

  byte_serializer_if bus_a ();
  byte_serializer_if bus_b ();
  byte_serializer_if bus_c ();

  byte_serializer #(.LSB_FIRST(1), .BIT_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  byte_serializer #(.LSB_FIRST(0), .BIT_CYCLES(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  byte_serializer #(.LSB_FIRST(1), .BIT_CYCLES(3)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [7:0] x);
    case (d)
      0:       begin bus_a.in_valid = v; bus_a.in_data = x; end
      1:       begin bus_b.in_valid = v; bus_b.in_data = x; end
      default: begin bus_c.in_valid = v; bus_c.in_data = x; end
    endcase
  endtask

  // {in_ready, sel[2:0], ser_out, ser_valid, ser_first, ser_last}
  function automatic logic [7:0] sample(input int d);
    case (d)
      0:       return {bus_a.in_ready, bus_a.sel, bus_a.ser_out, bus_a.ser_valid, bus_a.ser_first, bus_a.ser_last};
      1:       return {bus_b.in_ready, bus_b.sel, bus_b.ser_out, bus_b.ser_valid, bus_b.ser_first, bus_b.ser_last};
      default: return {bus_c.in_ready, bus_c.sel, bus_c.ser_out, bus_c.ser_valid, bus_c.ser_first, bus_c.ser_last};
    endcase
  endfunction

  task automatic check_idle(input int d, input string tag, input logic [2:0] exp_sel, input logic exp_rdy);
    logic [7:0] s;
    s = sample(d);
    check($sformatf("%s.ready", tag), 32'(s[7]),   32'(exp_rdy));
    check($sformatf("%s.sel", tag),   32'(s[6:4]), 32'(exp_sel));
    check($sformatf("%s.out", tag),   32'(s[3]),   32'(0));
    check($sformatf("%s.valid", tag), 32'(s[2]),   32'(0));
    check($sformatf("%s.first", tag), 32'(s[1]),   32'(0));
    check($sformatf("%s.last", tag),  32'(s[0]),   32'(0));
  endtask

  // stream[i] is the bit expected during bit period i of the frame.
  task automatic run_frame(input int d, input logic [7:0] stream, input logic lsb, input int bc,
                           input string tag, input int inj, input int rst_at);
    logic [7:0] s;
    int b;
    int es;
    for (int k = 0; k < 8 * bc; k++) begin
      b  = k / bc;
      es = lsb ? b : 7 - b;
      s  = sample(d);
      check($sformatf("%s.valid[%0d]", tag, k), 32'(s[2]),   32'(1));
      check($sformatf("%s.sel[%0d]", tag, k),   32'(s[6:4]), 32'(es));
      check($sformatf("%s.out[%0d]", tag, k),   32'(s[3]),   32'(stream[b]));
      check($sformatf("%s.first[%0d]", tag, k), 32'(s[1]),   32'(b == 0));
      check($sformatf("%s.last[%0d]", tag, k),  32'(s[0]),   32'(b == 7));
      check($sformatf("%s.ready[%0d]", tag, k), 32'(s[7]),   32'((b == 7) && (k % bc == bc - 1)));
      if (rst_at == b && k % bc == 0) begin
        rst = 1'b1;
        drive(d, 1'b1, 8'hE7);
        step();
        s = sample(d);
        check($sformatf("%s.rst_valid", tag), 32'(s[2]),   32'(0));
        check($sformatf("%s.rst_sel", tag),   32'(s[6:4]), 32'(0));
        check($sformatf("%s.rst_ready", tag), 32'(s[7]),   32'(0));
        return;
      end
      if (inj == b && k % bc == 0)
        drive(d, 1'b1, 8'h55);
      else if (inj >= 0 && k == inj * bc + 1)
        drive(d, 1'b0, 8'h00);
      step();
    end
  endtask

  initial begin
    checks = 0;
    errs   = 0;
    rst    = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    step();
    step();
    check_idle(0, "reset_a", 3'd0, 1'b0);
    check_idle(1, "reset_b", 3'd0, 1'b0);
    rst = 1'b0;
    #1;
    check_idle(0, "post_reset_a", 3'd0, 1'b1);
    check_idle(2, "post_reset_c", 3'd0, 1'b1);

    // T1: 8'hA5 LSB first -> 1,0,1,0,0,1,0,1
    drive(0, 1'b1, 8'hA5);
    step();
    drive(0, 1'b0, 8'h00);
    run_frame(0, 8'b1010_0101, 1'b1, 1, "t1", -1, -1);
    check_idle(0, "t1_idle", 3'd0, 1'b1);

    // T2: 8'h81 MSB first -> 1,0,0,0,0,0,0,1; sel ends wrapped back to 7
    drive(1, 1'b1, 8'h81);
    step();
    drive(1, 1'b0, 8'h00);
    run_frame(1, 8'b1000_0001, 1'b0, 1, "t2", -1, -1);
    check_idle(1, "t2_idle", 3'd7, 1'b1);

    // T3: back-to-back 8'hFF then 8'h00 with in_valid held high
    drive(0, 1'b1, 8'hFF);
    step();
    drive(0, 1'b1, 8'h00);
    run_frame(0, 8'b1111_1111, 1'b1, 1, "t3a", -1, -1);
    drive(0, 1'b0, 8'h00);
    run_frame(0, 8'b0000_0000, 1'b1, 1, "t3b", -1, -1);
    check_idle(0, "t3_idle", 3'd0, 1'b1);

    // T4: BIT_CYCLES=3, 8'h0F -> ones for 12 cycles, zeros for 12
    drive(2, 1'b1, 8'h0F);
    step();
    drive(2, 1'b0, 8'h00);
    run_frame(2, 8'b0000_1111, 1'b1, 3, "t4", -1, -1);
    check_idle(2, "t4_idle", 3'd0, 1'b1);

    // T5: 8'hC3 (1,1,0,0,0,0,1,1) with an 8'h55 pulse during bit 3
    drive(0, 1'b1, 8'hC3);
    step();
    drive(0, 1'b0, 8'h00);
    run_frame(0, 8'b1100_0011, 1'b1, 1, "t5", 3, -1);
    check_idle(0, "t5_idle", 3'd0, 1'b1);

    // T6: reset at bit 4 of 8'hF0, then a clean 8'h3C frame (0,0,1,1,1,1,0,0)
    drive(0, 1'b1, 8'hF0);
    step();
    drive(0, 1'b0, 8'h00);
    run_frame(0, 8'b1111_0000, 1'b1, 1, "t6a", -1, 4);
    step();
    check_idle(0, "t6_in_rst", 3'd0, 1'b0);
    rst = 1'b0;
    drive(0, 1'b1, 8'h3C);
    #1;
    check("t6.ready_after_rst", 32'(bus_a.in_ready), 32'(1));
    step();
    drive(0, 1'b0, 8'h00);
    run_frame(0, 8'b0011_1100, 1'b1, 1, "t6b", -1, -1);
    check_idle(0, "t6_idle", 3'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
